// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch and load/store.
// Optional feature macro: MEM_ARB_FAIR_EN (alternating grant when both sides contend).
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   inst_*                fetch requester (req/addr in, ok/rdata out)
//   data_*                load/store requester (req/wr/wstrb/addr/wdata in, ok/rdata out)
//   mem_*                 single external memory port
//   stallreq_for_mem      stall request to CTRL while any requester waits
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stallreq_for_mem
);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;
   state_t                r_state, w_next;
   logic                  r_owner;
   logic                  r_wr;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_inst_ok, r_data_ok;
   logic [DATA_W-1:0]     r_inst_rdata, r_data_rdata;
   logic                  w_grant_data, w_start, w_done;
`ifdef MEM_ARB_FAIR_EN
   logic                  r_last_grant;
   // inst wins a contended grant only when data had the previous one
   assign w_grant_data = data_req & ~(inst_req & r_last_grant);
`else
   assign w_grant_data = data_req;
`endif
   assign w_start = (r_state == IDLE) & (data_req | inst_req);
   // completion: data_ok in WAIT, or data_ok together with addr_ok in ADDR
   assign w_done  = mem_data_ok & (((r_state == ADDR) & mem_addr_ok) | (r_state == WAIT));
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (data_req | inst_req) ? ADDR : IDLE;
         ADDR:    w_next = mem_addr_ok ? (mem_data_ok ? IDLE : WAIT) : ADDR;
         WAIT:    w_next = mem_data_ok ? IDLE : WAIT;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner      <= 1'b0;
         r_wr         <= 1'b0;
         r_wstrb      <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_inst_ok    <= 1'b0;
         r_data_ok    <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
`ifdef MEM_ARB_FAIR_EN
         r_last_grant <= 1'b0;
`endif
      end else begin
         if (w_start) begin
            r_owner <= w_grant_data;
            r_wr    <= w_grant_data & data_wr;
            r_wstrb <= (w_grant_data & data_wr) ? data_wstrb : '0;
            r_addr  <= w_grant_data ? data_addr : inst_addr;
            r_wdata <= w_grant_data ? data_wdata : '0;
`ifdef MEM_ARB_FAIR_EN
            r_last_grant <= w_grant_data;
`endif
         end
         r_inst_ok <= w_done & ~r_owner;
         r_data_ok <= w_done & r_owner;
         if (w_done & ~r_wr & ~r_owner) r_inst_rdata <= mem_rdata;
         if (w_done & ~r_wr & r_owner)  r_data_rdata <= mem_rdata;
      end
   end
   assign mem_req          = (r_state == ADDR);
   assign mem_wr           = r_wr;
   assign mem_wstrb        = r_wstrb;
   assign mem_addr         = r_addr;
   assign mem_wdata        = r_wdata;
   assign inst_ok          = r_inst_ok;
   assign data_ok          = r_data_ok;
   assign inst_rdata       = r_inst_rdata;
   assign data_rdata       = r_data_rdata;
   assign stallreq_for_mem = (inst_req & ~inst_ok) | (data_req & ~data_ok);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        stallreq_for_mem;
   int          checks = 0;
   int          errors = 0;
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_ok(data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .stallreq_for_mem(stallreq_for_mem)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask
   // services one transaction starting at a negedge with the FSM in ADDR;
   // returns at the negedge where the ok pulse should be visible
   task automatic serve(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] wd, input int stalls, input logic comb, input logic [31:0] rd);
      for (int i = 0; i < stalls; i++) begin
         check({tag, "_stall_req"}, mem_req, 1);
         check({tag, "_stall_addr"}, mem_addr, a);
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b1;
         tick;
         check({tag, "_stall_no_ok"}, {inst_ok, data_ok}, 0);
      end
      mem_data_ok = 1'b0;
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_addr"}, mem_addr, a);
      check({tag, "_wr"}, mem_wr, w);
      check({tag, "_wstrb"}, mem_wstrb, s);
      check({tag, "_stallreq"}, stallreq_for_mem, 1);
      if (w) check({tag, "_wdata"}, mem_wdata, wd);
      mem_addr_ok = 1'b1;
      mem_data_ok = comb;
      mem_rdata   = rd;
      tick;
      mem_addr_ok = 1'b0;
      if (!comb) begin
         check({tag, "_wait_req"}, mem_req, 0);
         check({tag, "_wait_no_ok"}, {inst_ok, data_ok}, 0);
         mem_data_ok = 1'b1;
         tick;
      end
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
   endtask
   initial begin
      rst = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
      data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
      tick; tick;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_oks", {inst_ok, data_ok}, 0);
      check("rst_inst_rdata", inst_rdata, 0);
      check("rst_data_rdata", data_rdata, 0);
      check("rst_stall", stallreq_for_mem, 0);
      rst = 1'b1;
      tick;
      inst_req = 1; inst_addr = 32'hBFC00000;
      #1 check("fetch_stall_pre", stallreq_for_mem, 1);
      check("fetch_idle_req", mem_req, 0);
      tick;
      serve("fetch", 32'hBFC00000, 0, 4'h0, 0, 0, 0, 32'h3C010001);
      check("fetch_ok", inst_ok, 1);
      check("fetch_rdata", inst_rdata, 32'h3C010001);
      check("fetch_data_ok", data_ok, 0);
      check("fetch_stall_done", stallreq_for_mem, 0);
      inst_req = 0;
      tick;
      check("fetch_ok_pulse", inst_ok, 0);
      check("fetch_idle", mem_req, 0);
      inst_req = 1; inst_addr = 32'h100;
      data_req = 1; data_wr = 0; data_wstrb = 4'hF; data_addr = 32'h200; data_wdata = 32'h0;
      tick;
      serve("ld200", 32'h200, 0, 4'h0, 0, 0, 0, 32'hA5A50001);
      check("ld200_ok", data_ok, 1);
      check("ld200_rdata", data_rdata, 32'hA5A50001);
      check("ld200_inst_wait", inst_ok, 0);
      check("ld200_stall", stallreq_for_mem, 1);
      data_addr = 32'h300;
      tick;
`ifdef MEM_ARB_FAIR_EN
      serve("fair_inst", 32'h100, 0, 4'h0, 0, 0, 0, 32'h11111111);
      check("fair_inst_ok", inst_ok, 1);
      check("fair_inst_rdata", inst_rdata, 32'h11111111);
      inst_req = 0;
      tick;
      serve("fair_ld300", 32'h300, 0, 4'h0, 0, 0, 0, 32'h22222222);
      check("fair_ld300_ok", data_ok, 1);
      check("fair_ld300_rdata", data_rdata, 32'h22222222);
      data_req = 0;
      tick;
      check("fair_ok_pulse", data_ok, 0);
`else
      serve("prio_ld300", 32'h300, 0, 4'h0, 0, 0, 0, 32'h22222222);
      check("prio_ld300_ok", data_ok, 1);
      check("prio_ld300_rdata", data_rdata, 32'h22222222);
      data_req = 0;
      tick;
      serve("prio_inst", 32'h100, 0, 4'h0, 0, 0, 0, 32'h11111111);
      check("prio_inst_ok", inst_ok, 1);
      check("prio_inst_rdata", inst_rdata, 32'h11111111);
      inst_req = 0;
      tick;
      check("prio_ok_pulse", inst_ok, 0);
`endif
      data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h80000010; data_wdata = 32'h12345678;
      tick;
      serve("store", 32'h80000010, 1, 4'b0011, 32'h12345678, 0, 0, 32'hFFFFFFFF);
      check("store_ok", data_ok, 1);
      check("store_rdata_kept", data_rdata, 32'h22222222);
      data_req = 0; data_wr = 0; data_wstrb = 0;
      tick;
      check("store_ok_pulse", data_ok, 0);
      inst_req = 1; inst_addr = 32'h40;
      tick;
      serve("stall", 32'h40, 0, 4'h0, 0, 3, 0, 32'h55AA55AA);
      check("stall_ok", inst_ok, 1);
      check("stall_rdata", inst_rdata, 32'h55AA55AA);
      inst_req = 0;
      tick;
      data_req = 1; data_addr = 32'h44;
      tick;
      serve("comb", 32'h44, 0, 4'h0, 0, 0, 1, 32'hDEADBEEF);
      check("comb_ok", data_ok, 1);
      check("comb_rdata", data_rdata, 32'hDEADBEEF);
      data_addr = 32'h48;
      tick;
      check("comb_back_to_idle_req", mem_req, 1);
      check("comb_next_addr", mem_addr, 32'h48);
      check("comb_ok_pulse", data_ok, 0);
      serve("comb2", 32'h48, 0, 4'h0, 0, 0, 1, 32'hCAFEF00D);
      check("comb2_rdata", data_rdata, 32'hCAFEF00D);
      data_req = 0;
      tick;
      inst_req = 1; inst_addr = 32'h1000;
      tick;
      mem_addr_ok = 1;
      tick;
      mem_addr_ok = 0;
      inst_req = 0;
      #2 rst = 1'b0;
      #1 check("arst_mem_req", mem_req, 0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_oks", {inst_ok, data_ok}, 0);
      check("arst_inst_rdata", inst_rdata, 0);
      check("arst_data_rdata", data_rdata, 0);
      check("arst_stall", stallreq_for_mem, 0);
      @(negedge clk);
      rst = 1'b1;
      tick;
      check("arst_idle", mem_req, 0);
      inst_req = 1; inst_addr = 32'hBFC00004;
      tick;
      serve("refetch", 32'hBFC00004, 0, 4'h0, 0, 0, 0, 32'h24020005);
      check("refetch_ok", inst_ok, 1);
      check("refetch_rdata", inst_rdata, 32'h24020005);
      inst_req = 0;
      tick;
      check("refetch_ok_pulse", inst_ok, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the core's instruction-fetch side and its load/store side.
- Serialises requests through a grant FSM and returns read data to the requester that owns the transaction.
- Raises a stall request to CTRL while any requester is still waiting.
- Sits between the core's inst_sram/data_sram interfaces and the single external memory port.

Parameters:
ADDR_W, 32, address width of all address buses
DATA_W, 32, data width of read/write buses; byte strobe width is DATA_W/8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
inst_req  input  1  fetch request; held until inst_ok
inst_addr  input  ADDR_W  fetch address
inst_ok  output  1  one-cycle pulse: fetch complete
inst_rdata  output  DATA_W  fetch data; valid with inst_ok, held until the next inst_ok
data_req  input  1  load/store request; held until data_ok
data_wr  input  1  1 = store, 0 = load
data_wstrb  input  DATA_W/8  byte write strobes
data_addr  input  ADDR_W  load/store address
data_wdata  input  DATA_W  store data
data_ok  output  1  one-cycle pulse: load/store complete
data_rdata  output  DATA_W  load data; valid with data_ok on loads, held otherwise
mem_req  output  1  memory request
mem_wr  output  1  memory write
mem_wstrb  output  DATA_W/8  memory byte strobes (0 on reads)
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_addr_ok  input  1  memory accepted the address
mem_data_ok  input  1  memory completed the access
mem_rdata  input  DATA_W  memory read data, valid with mem_data_ok
stallreq_for_mem  output  1  stall request to CTRL

Behaviour:
- Reset (rst=0, async): FSM to IDLE. All outputs 0, including the rdata registers. The owner register clears to inst.
- FSM states:
  - IDLE: a request is pending if data_req or inst_req is high.
    - If data_req=1, latch wr/wstrb/addr/wdata, set owner=data, go to ADDR.
    - Else if inst_req=1, latch addr, set owner=inst, wr=0, wstrb=0, go to ADDR.
    - Otherwise stay in IDLE.
  - ADDR: mem_req=1; mem_* are driven only from the latched registers, never from live inputs.
    - On mem_addr_ok=1 go to WAIT.
    - If mem_addr_ok and mem_data_ok are both 1 in the same cycle, the access is complete: finish as in WAIT and go to IDLE.
    - mem_data_ok without mem_addr_ok is ignored.
  - WAIT: mem_req=0.
    - On mem_data_ok=1 go to IDLE.
    - Register the owner's ok pulse for the next cycle.
    - On reads, register mem_rdata into the owner's rdata at the same time.
- Ok pulses and rdata:
  - Registered outputs.
  - The ok pulse is high for exactly one cycle, in the cycle after mem_data_ok.
  - Stores pulse data_ok and leave data_rdata unchanged.
- Latency: request sampled in IDLE at cycle N, mem_req at N+1.
  - With mem_addr_ok at N+1 and mem_data_ok at N+2, the ok pulse is at N+3.
  - With addr_ok and data_ok in the same cycle at N+1, the ok pulse is at N+2.
- Arbitration: at most one outstanding memory transaction. The FSM is in IDLE for at least one cycle between transactions.
- stallreq_for_mem is combinational: (inst_req & ~inst_ok) | (data_req & ~data_ok).
- A requester dropping req mid-transaction is a protocol violation. The arbiter still completes the access and still pulses ok.
- Reset mid-transaction abandons the access. The memory shares rst, so no stale mem_data_ok is expected and none is tracked.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN
- Defined: a one-bit last_grant register (reset to inst) steers the choice in IDLE.
  - If both requests are pending and last_grant=data, inst is granted.
  - Otherwise data is granted.
  - last_grant updates on every grant.
- Undefined: data has strict priority over inst and last_grant is not implemented.

Test Plan:
- Fetch read: inst_req=1, inst_addr=0xBFC00000; memory addr_ok at once, data_ok next cycle with 0x3C010001 -> mem_addr=0xBFC00000, mem_wr=0, inst_ok pulse at N+3, inst_rdata=0x3C010001, stallreq_for_mem high until inst_ok.
- Store: data_req=1, data_wr=1, data_wstrb=4'b0011, data_addr=0x80000010, data_wdata=0x12345678 -> mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0x12345678; data_ok one cycle; data_rdata unchanged.
- Simultaneous requests, inst_addr=0x100, data_addr=0x200 (load) -> first mem_addr=0x200 and data_ok first, then mem_addr=0x100 and inst_ok. With MEM_ARB_FAIR_EN and both requests re-pending after the data grant, the next grant is inst.
- Memory stall: mem_addr_ok low for 3 cycles with mem_data_ok asserted spuriously in ADDR -> mem_req held for 3 cycles, mem_addr stable, spurious data_ok ignored, no ok pulse until the real mem_data_ok.
- Combined accept: mem_addr_ok and mem_data_ok high in the same cycle with rdata 0xDEADBEEF -> FSM goes to IDLE, ok pulse the next cycle, rdata=0xDEADBEEF.
- Async reset asserted in WAIT -> immediately FSM in IDLE, mem_req=0, ok pulses 0, rdata 0; after release a new fetch completes normally.
